line_raster: RTL

Parametrised Bresenham line rasteriser: it draws a segment between two unsigned endpoints in all octants and writes one pixel per cycle into a linear framebuffer at address y*FB_W + x. It sits between the primitive/command front end and the framebuffer write port. Compared with the current line_drawing block it adds:
- multi-bit colour channels,
- configurable framebuffer geometry,
- screen clipping,
- write back-pressure,
- a busy flag and a written-pixel count.

---
 rtl/line_raster.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/line_raster.sv
// rtl/line_raster.sv - Bresenham line rasteriser writing clipped pixels into a linear framebuffer.
// Handles all octants, with write back-pressure, a busy flag and a count of written pixels.
module line_raster #(
  parameter int WIDTH      = 13,
  parameter int COLOR_BITS = 1,
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int ADDR_W     = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COLOR_BITS-1:0] red_in,
  input  logic [COLOR_BITS-1:0] green_in,
  input  logic [COLOR_BITS-1:0] blue_in,
  input  logic [WIDTH-1:0]      x0,
  input  logic [WIDTH-1:0]      y0,
  input  logic [WIDTH-1:0]      x1,
  input  logic [WIDTH-1:0]      y1,
  input  logic                  FB_ready,
  output logic                  FB_WE,
  output logic [ADDR_W-1:0]     FB_addr,
  output logic [COLOR_BITS-1:0] red_out,
  output logic [COLOR_BITS-1:0] green_out,
  output logic [COLOR_BITS-1:0] blue_out,
  output logic                  busy,
  output logic                  sys_finish,
  output logic [WIDTH:0]        pix_count
);

  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]        r_x0, r_y0, r_x1, r_y1;
  logic [WIDTH-1:0]        r_x, r_y;
  logic signed [EW-1:0]    r_err, r_dx, r_dy;
  logic                    r_sx_neg, r_sy_neg;
  logic [COLOR_BITS-1:0]   r_red, r_green, r_blue;
  logic [WIDTH:0]          r_pix_count;

  logic [WIDTH-1:0]        w_adx, w_ady;
  logic                    w_in_bounds, w_we, w_retire, w_last;
  logic signed [EW:0]      w_e2, w_dx_ext, w_dy_ext;
  logic                    w_step_x, w_step_y;
  logic signed [EW-1:0]    w_err_nxt;
  logic [ADDR_W-1:0]       w_addr;

  assign w_adx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_ady = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

  assign w_in_bounds = (32'(r_x) < FB_W) && (32'(r_y) < FB_H);
  assign w_we        = (r_state == S_DRAW) && w_in_bounds;
  // Clipped pixels retire unconditionally; visible ones wait for the framebuffer.
  assign w_retire    = (r_state == S_DRAW) && (!w_in_bounds || FB_ready);
  assign w_last      = (r_x == r_x1) && (r_y == r_y1);
  assign w_addr      = ADDR_W'(r_y) * ADDR_W'(FB_W) + ADDR_W'(r_x);

  assign w_e2     = {r_err, 1'b0};
  assign w_dx_ext = {r_dx[EW-1], r_dx};
  assign w_dy_ext = {r_dy[EW-1], r_dy};
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);

  always_comb begin
    w_err_nxt = r_err;
    if (w_step_x) w_err_nxt = w_err_nxt + r_dy;
    if (w_step_y) w_err_nxt = w_err_nxt + r_dx;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = S_DRAW;
      S_DRAW:  if (w_retire && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_err       <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_sx_neg    <= 1'b0;
      r_sy_neg    <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_pix_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x0        <= x0;
            r_y0        <= y0;
            r_x1        <= x1;
            r_y1        <= y1;
            r_red       <= red_in;
            r_green     <= green_in;
            r_blue      <= blue_in;
            r_pix_count <= '0;
          end
        end
        S_SETUP: begin
          r_dx     <= $signed({2'b00, w_adx});
          r_dy     <= -$signed({2'b00, w_ady});
          r_err    <= $signed({2'b00, w_adx}) - $signed({2'b00, w_ady});
          r_sx_neg <= !(r_x0 < r_x1);
          r_sy_neg <= !(r_y0 < r_y1);
          r_x      <= r_x0;
          r_y      <= r_y0;
        end
        S_DRAW: begin
          if (w_retire) begin
            if (w_we) r_pix_count <= r_pix_count + 1'b1;
            if (!w_last) begin
              r_err <= w_err_nxt;
              if (w_step_x) r_x <= r_sx_neg ? (r_x - 1'b1) : (r_x + 1'b1);
              if (w_step_y) r_y <= r_sy_neg ? (r_y - 1'b1) : (r_y + 1'b1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign FB_WE      = w_we;
  assign FB_addr    = w_we ? w_addr : '0;
  assign busy       = (r_state != S_IDLE);
  assign sys_finish = (r_state == S_DONE);
  assign red_out    = r_red;
  assign green_out  = r_green;
  assign blue_out   = r_blue;
  assign pix_count  = r_pix_count;

endmodule
